// File: rtl/dmem_stream_reader.sv
// Streams a block of 32-bit words from data-memory port B as little-endian bytes.
// Keeps at most two words buffered or in flight so reads overlap the byte output.
module dmem_stream_reader #(
  parameter int unsigned DEPTH = 70000,
  parameter int unsigned AW    = 17
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [AW-1:0] base,
  input  logic [AW-1:0] count,
  output logic [31:0]   rd_addr,
  input  logic [31:0]   rd_data,
  output logic [7:0]    out_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          busy,
  output logic          done
);

  typedef enum logic [1:0] {StIdle, StRun, StFin} state_e;

  state_e        state;
  logic [AW-1:0] addr;
  logic [AW-1:0] rd_addr_r;
  logic [AW-1:0] cnt;
  logic [AW-1:0] issued;
  logic [AW-1:0] popped;
  logic          cap1;
  logic          cap2;
  logic [31:0]   fifo_mem [2];
  logic          fifo_rp;
  logic          fifo_wp;
  logic [1:0]    fifo_cnt;
  logic [31:0]   cur_word;
  logic [1:0]    byte_idx;

  logic          fire;
  logic          last_byte;
  logic          need_word;
  logic          issue;
  logic          fifo_pop;
  logic          bypass;
  logic          push;
  logic          final_pop;
  logic [AW-1:0] outstanding;

  function automatic logic [AW-1:0] next_addr(input logic [AW-1:0] a);
    if (a == AW'(DEPTH - 1)) return '0;
    return a + AW'(1);
  endfunction

  assign rd_addr = {{(32 - AW){1'b0}}, rd_addr_r};

  always_comb begin
    fire        = out_valid && out_ready;
    last_byte   = fire && (byte_idx == 2'd3);
    need_word   = !out_valid || last_byte;
    outstanding = issued - popped;
    // Credit counts words issued but not fully serialized: in flight, queued or being emitted.
    issue       = (state == StRun) && (issued != cnt) && (outstanding < AW'(2));
    fifo_pop    = need_word && (fifo_cnt != 2'd0);
    // Data arriving while the serializer is starved goes straight to the output register.
    bypass      = need_word && (fifo_cnt == 2'd0) && cap2;
    push        = cap2 && !bypass;
    final_pop   = last_byte && (popped == cnt - AW'(1));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= StIdle;
      addr      <= '0;
      rd_addr_r <= '0;
      cnt       <= '0;
      issued    <= '0;
      popped    <= '0;
      cap1      <= 1'b0;
      cap2      <= 1'b0;
      fifo_rp   <= 1'b0;
      fifo_wp   <= 1'b0;
      fifo_cnt  <= 2'd0;
      cur_word  <= '0;
      byte_idx  <= 2'd0;
      out_data  <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      cap1 <= 1'b0;
      cap2 <= cap1;

      unique case (state)
        StIdle: begin
          if (start) begin
            if (count == '0) begin
              done <= 1'b1;
            end else begin
              // The first read issues on the accepting edge.
              cnt       <= count;
              issued    <= AW'(1);
              popped    <= '0;
              rd_addr_r <= base;
              addr      <= next_addr(base);
              cap1      <= 1'b1;
              busy      <= 1'b1;
              state     <= StRun;
            end
          end
        end
        StRun: begin
          if (issue) begin
            rd_addr_r <= addr;
            addr      <= next_addr(addr);
            issued    <= issued + AW'(1);
            cap1      <= 1'b1;
          end
          if (last_byte) popped <= popped + AW'(1);
          if (final_pop) begin
            state <= StFin;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        StFin: begin
          state <= StIdle;
        end
        default: begin
          state <= StIdle;
        end
      endcase

      if (push) begin
        fifo_mem[fifo_wp] <= rd_data;
        fifo_wp           <= ~fifo_wp;
      end
      if (fifo_pop) fifo_rp <= ~fifo_rp;
      unique case ({push, fifo_pop})
        2'b10:   fifo_cnt <= fifo_cnt + 2'd1;
        2'b01:   fifo_cnt <= fifo_cnt - 2'd1;
        default: fifo_cnt <= fifo_cnt;
      endcase

      if (need_word) begin
        if (fifo_pop) begin
          cur_word  <= fifo_mem[fifo_rp];
          out_data  <= fifo_mem[fifo_rp][7:0];
          byte_idx  <= 2'd0;
          out_valid <= 1'b1;
        end else if (bypass) begin
          cur_word  <= rd_data;
          out_data  <= rd_data[7:0];
          byte_idx  <= 2'd0;
          out_valid <= 1'b1;
        end else begin
          out_valid <= 1'b0;
        end
      end else if (fire) begin
        cur_word <= {8'h00, cur_word[31:8]};
        out_data <= cur_word[15:8];
        byte_idx <= byte_idx + 2'd1;
      end
    end
  end

endmodule

// File: tb/tb_dmem_stream_reader.sv
// Directed bench for dmem_stream_reader with a registered-read memory model on port B.
module tb_dmem_stream_reader;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [16:0] base;
  logic [16:0] count;
  logic [31:0] rd_addr;
  logic [31:0] rd_data;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready;
  logic        busy;
  logic        done;

  logic [31:0] mem [0:69999];
  logic [7:0]  exp_b [16];
  logic [16:0] exp_a [4];
  logic [3:0]  pat = 4'b1001;
  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] hold_addr;

  dmem_stream_reader #(.DEPTH(70000), .AW(17)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .base      (base),
    .count     (count),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) rd_data <= mem[rd_addr[16:0]];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic set_two_word();
    exp_a[0] = 17'h10;
    exp_a[1] = 17'h11;
    exp_b[0] = 8'h11; exp_b[1] = 8'h22; exp_b[2] = 8'h33; exp_b[3] = 8'h44;
    exp_b[4] = 8'h55; exp_b[5] = 8'h66; exp_b[6] = 8'h77; exp_b[7] = 8'h88;
  endtask

  // Starts a transfer and follows it to done, checking bytes, addresses and stalls.
  task automatic run_stream(input logic [16:0] b, input logic [16:0] c, input bit stall,
                            input int inject_at);
    int          nacc = 0;
    int          n_iss = 0;
    int          nbytes;
    logic [31:0] prev_a;
    bit          prev_stall = 0;
    logic [7:0]  prev_d = 8'h00;
    bit          got_done = 0;
    nbytes = 4 * int'(c);
    prev_a = rd_addr;
    base   = b;
    count  = c;
    start  = 1'b1;
    step();
    start  = 1'b0;
    for (int cyc = 0; cyc < 300 && !got_done; cyc++) begin
      start = (cyc == inject_at);
      if (cyc == inject_at) begin
        base  = 17'h200;
        count = 17'd5;
      end
      out_ready = stall ? pat[cyc % 4] : 1'b1;
      if (rd_addr !== prev_a) begin
        if (n_iss < int'(c)) check("rd_addr_seq", rd_addr, {15'd0, exp_a[n_iss]});
        n_iss++;
        prev_a = rd_addr;
        check("reads_ahead_le_2", 32'((n_iss - nacc / 4) <= 2), 32'd1);
      end
      if (done) begin
        got_done = 1;
        check("done_after_last_byte", nacc, nbytes);
        check("busy_in_fin", busy, 0);
      end else begin
        check("busy_in_run", busy, 1);
        if (prev_stall) begin
          check("valid_held", out_valid, 1);
          check("data_held", out_data, prev_d);
        end
        if (out_valid && out_ready) begin
          if (nacc < nbytes) check("stream_byte", out_data, exp_b[nacc]);
          else check("byte_count", nacc + 1, nbytes);
          nacc++;
        end
        prev_stall = out_valid && !out_ready;
        prev_d     = out_data;
        step();
      end
    end
    start = 1'b0;
    check("stream_done_seen", got_done, 1);
    check("read_count", n_iss, int'(c));
    step();
    check("done_one_cycle", done, 0);
    check("valid_after_done", out_valid, 0);
    out_ready = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < 70000; i++) mem[i] = 32'h0;
    mem[17'h10]  = 32'h44332211;
    mem[17'h11]  = 32'h88776655;
    mem[17'h20]  = 32'h03020100;
    mem[17'h21]  = 32'h17161514;
    mem[17'h22]  = 32'h27262524;
    mem[17'h23]  = 32'h37363534;
    mem[69999]   = 32'hDDCCBBAA;
    mem[0]       = 32'h04030201;
    mem[1]       = 32'h0D0C0B0A;
    rst       = 1'b1;
    start     = 1'b0;
    base      = '0;
    count     = '0;
    out_ready = 1'b1;
    step();
    step();
    rst = 1'b0;
    check("reset_rd_addr", rd_addr, 0);
    check("reset_out_data", out_data, 0);
    check("reset_out_valid", out_valid, 0);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);

    // Cycle-exact two-word transfer.
    set_two_word();
    base  = 17'h10;
    count = 17'd2;
    start = 1'b1;
    step();
    start = 1'b0;
    check("n1_busy", busy, 1);
    check("n1_rd_addr", rd_addr, 32'h10);
    check("n1_valid", out_valid, 0);
    step();
    check("n2_rd_addr", rd_addr, 32'h11);
    check("n2_valid", out_valid, 0);
    for (int k = 0; k < 8; k++) begin
      step();
      check("nobubble_valid", out_valid, 1);
      check("nobubble_byte", out_data, exp_b[k]);
    end
    step();
    check("n11_done", done, 1);
    check("n11_busy", busy, 0);
    check("n11_valid", out_valid, 0);
    step();
    check("n12_done", done, 0);

    // Same transfer with back-pressure.
    set_two_word();
    run_stream(17'h10, 17'd2, 1'b1, -1);

    // Address wrap at the top of memory.
    exp_a[0] = 17'd69999;
    exp_a[1] = 17'd0;
    exp_a[2] = 17'd1;
    exp_b[0] = 8'hAA; exp_b[1] = 8'hBB; exp_b[2]  = 8'hCC; exp_b[3]  = 8'hDD;
    exp_b[4] = 8'h01; exp_b[5] = 8'h02; exp_b[6]  = 8'h03; exp_b[7]  = 8'h04;
    exp_b[8] = 8'h0A; exp_b[9] = 8'h0B; exp_b[10] = 8'h0C; exp_b[11] = 8'h0D;
    run_stream(17'd69999, 17'd3, 1'b0, -1);

    // Zero-length request.
    hold_addr = rd_addr;
    base  = 17'h55;
    count = 17'd0;
    start = 1'b1;
    step();
    start = 1'b0;
    check("zero_done", done, 1);
    check("zero_busy", busy, 0);
    check("zero_rd_addr", rd_addr, hold_addr);
    step();
    check("zero_done_cleared", done, 0);
    for (int k = 0; k < 4; k++) begin
      check("zero_valid", out_valid, 0);
      check("zero_addr_held", rd_addr, hold_addr);
      step();
    end

    // Start pulsed during RUN is ignored.
    set_two_word();
    run_stream(17'h10, 17'd2, 1'b0, 4);

    // Reset mid-stream, then a fresh transfer.
    base  = 17'h20;
    count = 17'd4;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int k = 0; k < 6; k++) step();
    check("fifth_byte", out_data, 32'h14);
    check("fifth_valid", out_valid, 1);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("rst_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_rd_addr", rd_addr, 0);
    set_two_word();
    run_stream(17'h10, 17'd2, 1'b0, -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
